raif_wr_dma: RTL and testbench
==============================

RAIF_WR_DMA -- requirements
Module: raif_wr_dma

Interface
REQ-001 The block SHALL have parameter APP_ADDR_WIDTH, default 28, DRAM address width.
REQ-002 The block SHALL have parameter APP_DATA_WIDTH, default 128, data beat width.
REQ-003 The block SHALL have parameter BURST_LEN, default 64, maximum wr_num per request, range 1..512.
REQ-004 The block SHALL have parameter ADDR_STEP, default 8, address increment per data beat.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 256, a power of two and at least BURST_LEN.
REQ-006 The block SHALL have parameter PREFETCH, default 1; 1 selects pre-fetched wr_data, 0 selects non-pre-fetched wr_data.
REQ-007 clk  in  1  sole clock; rst_n  in  1  reset, synchronous and active-low.
REQ-008 start  in  1  single-cycle job start; base_addr  in  APP_ADDR_WIDTH  job start address; total_beats  in  24  job length in beats.
REQ-009 busy  out  1  job active; done  out  1  single-cycle job-complete pulse; err  out  1  sticky protocol error.
REQ-010 s_data  in  APP_DATA_WIDTH  stream beat; s_valid  in  1  beat valid; s_ready  out  1  FIFO can accept.
REQ-011 wr_req  out  1; wr_addr  out  APP_ADDR_WIDTH; wr_num  out  10; wr_data  out  APP_DATA_WIDTH; wr_mask  out  APP_DATA_WIDTH/8; wr_grant  in  1; wr_finish  in  1. These ports form the RAIF write master that drives one RAWR_RCIF channel of the arbiter.

Function
REQ-012 The internal FIFO SHALL have FIFO_DEPTH entries; a beat is written when s_valid&s_ready; s_ready = !full, and it is valid during and outside jobs.
REQ-013 The FSM SHALL have states IDLE, WAIT_DATA, REQ, DONE.
REQ-014 In IDLE with start=1 and total_beats!=0, the block SHALL latch addr=base_addr and remaining=total_beats and go to WAIT_DATA; with total_beats=0 it SHALL go directly to DONE.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 Burst size SHALL be num = min(BURST_LEN, remaining).
REQ-017 In WAIT_DATA, when FIFO count >= num, the block SHALL go to REQ and, in the same registered update, drive wr_req=1, wr_addr=addr, wr_num=num.
REQ-018 In REQ, wr_req, wr_addr and wr_num SHALL stay constant until wr_finish is sampled high.
REQ-019 Each cycle with wr_grant=1 SHALL pop exactly one FIFO entry.
REQ-020 When PREFETCH=1, wr_data SHALL equal the FIFO head combinationally, so the beat is valid in the grant cycle.
REQ-021 When PREFETCH=0, wr_data SHALL be a register loaded from the FIFO head on the pop, so the beat is valid the cycle after the grant.
REQ-022 wr_mask SHALL be all zeros (all bytes written).
REQ-023 On wr_finish, wr_req SHALL be 0 from the next cycle; addr SHALL advance by num*ADDR_STEP, modulo 2^APP_ADDR_WIDTH (wrap allowed); remaining SHALL decrease by num.
REQ-024 After that update, the FSM SHALL go to DONE if remaining=0, else to WAIT_DATA.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in WAIT_DATA and REQ.
REQ-027 err SHALL set and hold on: wr_grant while the FIFO is empty (no pop); more than num grants in one request; wr_grant or wr_finish outside REQ.
REQ-028 err SHALL clear only on reset.
REQ-029 A simultaneous FIFO push and pop SHALL leave the count unchanged; pushing when full is blocked by s_ready=0.

Reset
REQ-030 With rst_n=0 at a clk edge, the block SHALL enter IDLE and empty the FIFO, driving wr_req=0, wr_addr=0, wr_num=0, wr_data=0, wr_mask=0, busy=0, done=0, err=0, s_ready=1 from the next cycle.
REQ-031 Reset during REQ SHALL abandon the burst with no finish handshake; the arbiter is reset with it.

Verification
REQ-032 Single burst: base_addr=0x100, total_beats=16, 16 beats preloaded, grant 16 cycles then finish -> one request wr_addr=0x100, wr_num=16, data in order, done pulse, busy=0.
REQ-033 Split job: total_beats=150, BURST_LEN=64 -> three requests, wr_num 64/64/22 at addresses base, base+512, base+1024.
REQ-034 Starvation: total_beats=64 with only 40 beats pushed -> wr_req stays 0 until the 64th beat is pushed, then asserts the next cycle.
REQ-035 PREFETCH=0, beats 0..7 -> wr_data shows beat k one cycle after the k-th grant; PREFETCH=1 -> wr_data shows beat k in the k-th grant cycle.
REQ-036 Wrap and error: APP_ADDR_WIDTH=12, base_addr=0xFF8, two 1-beat bursts -> second wr_addr=0x000. Then a grant while the FIFO is empty -> err=1, held until rst_n=0.
REQ-037 Boundaries: total_beats=0 -> done on the second cycle after start, no wr_req. FIFO full -> s_ready=0. Reset mid-REQ -> all outputs at reset values from the next cycle.

Source files
------------

// File: rtl/raif_wr_dma.sv
// RAIF write DMA: buffers a beat stream in a FIFO and issues bursts of up to
// BURST_LEN beats on one RAIF write-master channel until the job length is consumed.
module raif_wr_dma #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int BURST_LEN      = 64,
    parameter int ADDR_STEP      = 8,
    parameter int FIFO_DEPTH     = 256,
    parameter int PREFETCH       = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [APP_ADDR_WIDTH-1:0]   base_addr,
    input  logic [23:0]                 total_beats,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  logic [APP_DATA_WIDTH-1:0]   s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        wr_req,
    output logic [APP_ADDR_WIDTH-1:0]   wr_addr,
    output logic [9:0]                  wr_num,
    output logic [APP_DATA_WIDTH-1:0]   wr_data,
    output logic [APP_DATA_WIDTH/8-1:0] wr_mask,
    input  logic                        wr_grant,
    input  logic                        wr_finish
);

    localparam int CW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        REQ,
        DONE
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [APP_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]             wr_ptr;
    logic [CW-1:0]             rd_ptr;
    logic [CW:0]               count;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic [APP_DATA_WIDTH-1:0] head;

    assign full    = (count == (CW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign pop     = wr_grant && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array carries no reset; emptiness is tracked by count,
    // so stale entries are never observable and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------- job sequencer
    state_t                    state;
    logic [APP_ADDR_WIDTH-1:0] addr;
    logic [23:0]               remaining;
    logic [9:0]                grant_cnt;
    logic [9:0]                num;
    logic [23:0]               rem_next;
    logic [APP_ADDR_WIDTH-1:0] addr_next;
    logic                      data_ready;
    logic                      err_evt;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        num = 10'(BURST_LEN);
        if (remaining < 24'(BURST_LEN)) begin
            num = remaining[9:0];
        end
        data_ready = (32'(count) >= 32'(num));
        rem_next   = remaining - 24'(wr_num);
        addr_next  = addr + APP_ADDR_WIDTH'(32'(wr_num) * ADDR_STEP);
        err_evt    = 1'b0;
        if (wr_grant && empty) begin
            err_evt = 1'b1;
        end
        if ((wr_grant || wr_finish) && state != REQ) begin
            err_evt = 1'b1;
        end
        if (wr_grant && state == REQ && grant_cnt >= wr_num) begin
            err_evt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            grant_cnt <= '0;
            wr_req    <= 1'b0;
            wr_addr   <= '0;
            wr_num    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (err_evt) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (total_beats != '0) begin
                            addr      <= base_addr;
                            remaining <= total_beats;
                            busy      <= 1'b1;
                            state     <= WAIT_DATA;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (data_ready) begin
                        wr_req    <= 1'b1;
                        wr_addr   <= addr;
                        wr_num    <= num;
                        grant_cnt <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (wr_grant) begin
                        grant_cnt <= grant_cnt + 10'd1;
                    end
                    if (wr_finish) begin
                        wr_req    <= 1'b0;
                        addr      <= addr_next;
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ data path
    generate
        if (PREFETCH != 0) begin : g_prefetch
            // Head is forced to zero when empty so reset and drained states read 0.
            assign wr_data = empty ? '0 : head;
        end else begin : g_registered
            logic [APP_DATA_WIDTH-1:0] data_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (pop) begin
                    data_q <= head;
                end
            end
            assign wr_data = data_q;
        end
    endgenerate

    assign wr_mask = '0;

endmodule

// File: tb/tb_raif_wr_dma.sv
// Randomized bench for raif_wr_dma: the bench acts as stream source and arbiter,
// checking both data-path variants against a queue-based model of the job.
module tb_raif_wr_dma;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int BL    = 64;
    localparam int STEP  = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [23:0]   total_beats = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          wr_grant = 1'b0;
    logic          wr_finish = 1'b0;

    logic          busy_a, done_a, err_a, s_ready_a, wr_req_a;
    logic [AW-1:0] wr_addr_a;
    logic [9:0]    wr_num_a;
    logic [DW-1:0] wr_data_a;
    logic [3:0]    wr_mask_a;
    logic          busy_b, done_b, err_b, s_ready_b, wr_req_b;
    logic [AW-1:0] wr_addr_b;
    logic [9:0]    wr_num_b;
    logic [DW-1:0] wr_data_b;
    logic [3:0]    wr_mask_b;

    raif_wr_dma #(
        .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .BURST_LEN(BL),
        .ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH), .PREFETCH(1)
    ) dut_pf (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .total_beats(total_beats), .busy(busy_a), .done(done_a), .err(err_a),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
        .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_num(wr_num_a),
        .wr_data(wr_data_a), .wr_mask(wr_mask_a),
        .wr_grant(wr_grant), .wr_finish(wr_finish)
    );

    raif_wr_dma #(
        .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .BURST_LEN(BL),
        .ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH), .PREFETCH(0)
    ) dut_np (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .total_beats(total_beats), .busy(busy_b), .done(done_b), .err(err_b),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
        .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_num(wr_num_b),
        .wr_data(wr_data_b), .wr_mask(wr_mask_b),
        .wr_grant(wr_grant), .wr_finish(wr_finish)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fq[$];       // model of FIFO contents, head at index 0
    int            to_push = 0;
    int            prob = 100;
    bit            noise = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: optional random push (and, with noise on, stray start pulses).
    task automatic step();
        bit            p;
        logic [DW-1:0] d;
        p = (to_push > 0) && (int'($urandom_range(99)) < prob);
        d = $urandom;
        s_valid = p;
        s_data  = d;
        if (noise) begin
            start       = ($urandom_range(7) == 0);
            base_addr   = AW'($urandom);
            total_beats = 24'($urandom_range(300));
        end
        p = p && s_ready_a;
        tick();
        if (p) begin
            fq.push_back(d);
            to_push--;
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"},
              32'({wr_req_a, busy_a, done_a, err_a, s_ready_a,
                   wr_req_b, busy_b, done_b, err_b, s_ready_b}),
              32'(10'b00001_00001));
        check({tag, "_addr"}, 32'({wr_addr_a, wr_addr_b}), 32'(0));
        check({tag, "_num"},  32'({wr_num_a, wr_num_b}), 32'(0));
        check({tag, "_data_pf"}, wr_data_a, 32'(0));
        check({tag, "_data_np"}, wr_data_b, 32'(0));
        check({tag, "_mask"}, 32'({wr_mask_a, wr_mask_b}), 32'(0));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        wr_grant = 1'b0;
        wr_finish = 1'b0;
        noise = 1'b0;
        to_push = 0;
        step();
        check_reset_vals(tag);
        step();
        rst_n = 1'b1;
        fq.delete();
    endtask

    task automatic preload(input int n);
        to_push = n;
        prob = 100;
        for (int i = 0; i < n + 4 && to_push > 0; i++) step();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 3000 && !wr_req_a; i++) step();
        check("wr_req_rise", 32'(wr_req_a), 32'(1));
    endtask

    // Arbiter side of one request: grant en cycles, then finish.
    task automatic serve_burst(input logic [AW-1:0] ea, input int en);
        logic [DW-1:0] prev;
        prev = '0;
        check("req_addr", 32'(wr_addr_a), 32'(ea));
        check("req_num", 32'(wr_num_a), en);
        check("req_np", 32'({wr_req_b, wr_num_b, wr_addr_b}), 32'({1'b1, 10'(en), ea}));
        for (int k = 0; k < en; k++) begin
            if (fq.size() == 0) begin
                check("model_head_avail", 32'(fq.size()), 32'(1));
                break;
            end
            wr_grant = 1'b1;
            #1;
            check("wr_data_pf", wr_data_a, fq[0]);
            if (k > 0) check("wr_data_np", wr_data_b, prev);
            check("req_hold", 32'({wr_req_a, wr_num_a, wr_addr_a}), 32'({1'b1, 10'(en), ea}));
            prev = fq.pop_front();
            step();
        end
        wr_grant = 1'b0;
        #1;
        check("wr_data_np_last", wr_data_b, prev);
        check("req_hold_last", 32'(wr_req_a), 32'(1));
        wr_finish = 1'b1;
        step();
        wr_finish = 1'b0;
        #1;
        check("req_drop", 32'({wr_req_a, wr_req_b}), 32'(0));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10 && !done_a; i++) step();
        check("done_pulse", 32'({done_a, done_b}), 32'(2'b11));
        check("done_idle", 32'({busy_a, wr_req_a, busy_b}), 32'(0));
        step();
        check("done_single", 32'({done_a, done_b}), 32'(0));
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int total, input int pr, input bit nz);
        int            off;
        int            n;
        logic [AW-1:0] a;
        to_push = (total > fq.size()) ? total - fq.size() : 0;
        prob = pr;
        base_addr = base;
        total_beats = 24'(total);
        start = 1'b1;
        step();
        if (total == 0) begin
            check("zero_done", 32'(done_a), 32'(1));
            check("zero_busy", 32'({busy_a, wr_req_a}), 32'(0));
        end else begin
            check("job_busy", 32'({busy_a, busy_b}), 32'(2'b11));
        end
        noise = nz;
        off = 0;
        while (off < total) begin
            n = (total - off > BL) ? BL : total - off;
            a = AW'(int'(base) + off * STEP);
            wait_req();
            serve_burst(a, n);
            off += n;
        end
        noise = 1'b0;
        wait_done();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("reset");

        // Single 16-beat burst, then a 150-beat job split 64/64/22.
        preload(16);
        run_job(12'h100, 16, 100, 1'b0);
        preload(150);
        run_job(12'h100, 150, 100, 1'b0);

        // Starvation: request must wait for the 64th beat.
        prob = 100;
        base_addr = 12'h040;
        total_beats = 24'd64;
        start = 1'b1;
        step();
        to_push = 40;
        for (int i = 0; i < 40; i++) begin
            step();
            check("starve_40", 32'(wr_req_a), 32'(0));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check("starve_idle", 32'(wr_req_a), 32'(0));
        end
        to_push = 24;
        for (int i = 0; i < 24; i++) begin
            step();
            check("starve_64", 32'(wr_req_a), 32'(0));
        end
        step();
        check("starve_rise", 32'(wr_req_a), 32'(1));
        serve_burst(12'h040, 64);
        wait_done();

        // Address wrap: second burst lands at 0xE00 + 512 = 0x000.
        preload(70);
        run_job(12'hE00, 70, 100, 1'b0);

        // Zero-length job.
        run_job(12'h123, 0, 100, 1'b0);

        // Fill the FIFO, check back-pressure, then drain it with one job.
        to_push = DEPTH + 4;
        prob = 100;
        for (int i = 0; i < DEPTH + 4; i++) step();
        check("full_s_ready", 32'({s_ready_a, s_ready_b}), 32'(0));
        check("full_level", 32'(fq.size()), 32'(DEPTH));
        to_push = 0;
        run_job(12'h200, DEPTH, 100, 1'b0);
        check("drained_s_ready", 32'(s_ready_a), 32'(1));

        // Random jobs with concurrent pushes and stray starts.
        for (int r = 0; r < 6; r++) begin
            int            total;
            logic [AW-1:0] base;
            total = int'($urandom_range(200, 1));
            base  = AW'($urandom);
            preload(int'($urandom_range(total, 0)));
            run_job(base, total, int'($urandom_range(100, 30)), 1'b1);
        end
        check("no_err_normal", 32'({err_a, err_b}), 32'(0));

        // Reset in the middle of a request.
        preload(8);
        base_addr = 12'h300;
        total_beats = 24'd8;
        start = 1'b1;
        step();
        wait_req();
        wr_grant = 1'b1;
        for (int i = 0; i < 3; i++) step();
        do_reset("rst_mid_req");

        // Finish outside a request.
        wr_finish = 1'b1;
        step();
        wr_finish = 1'b0;
        check("err_finish_idle", 32'({err_a, err_b}), 32'(2'b11));
        do_reset("rst_err1");

        // One grant more than wr_num.
        preload(5);
        base_addr = 12'h010;
        total_beats = 24'd2;
        start = 1'b1;
        step();
        wait_req();
        check("err_num", 32'(wr_num_a), 32'(2));
        wr_grant = 1'b1;
        step();
        step();
        check("err_two_grants", 32'(err_a), 32'(0));
        step();
        wr_grant = 1'b0;
        check("err_extra_grant", 32'({err_a, err_b}), 32'(2'b11));
        do_reset("rst_err2");

        // Grant with an empty FIFO; error is sticky until reset.
        wr_grant = 1'b1;
        step();
        wr_grant = 1'b0;
        check("err_empty_grant", 32'(err_a), 32'(1));
        for (int i = 0; i < 4; i++) step();
        check("err_sticky", 32'({err_a, err_b}), 32'(2'b11));
        do_reset("rst_err3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
